// File: rtl/nn_layer_stream.sv
// Fully-connected layer: NEURON_NUM neurons share one serial input stream; results are either streamed or reduced to argmax.
// Latency: last input beat -> first output = neuron latency (1) + 1 capture cycle (+ NEURON_NUM scan cycles in argmax mode).
// Backpressure: in_ready drops from the last input beat until the sample has left; outputs hold stable until out_ready.
//
// Ports: clk/rst_n (async active-low); in_data/in_valid/in_ready serial input words;
//        out_data/out_valid/out_ready/out_last result stream (or one argmax index word);
//        busy = not accepting input; err_unexp = sticky flag for a neuron result arriving unexpectedly.

module nn_neuron #(
    parameter int                            DATA_WIDTH       = 16,
    parameter int                            WEIGHT_NUM       = 30,
    parameter int                            WEIGHT_INT_WIDTH = 4,
    parameter int                            SIGMOID_SIZE     = 10,
    parameter int                            LAYER_NO         = 4,
    parameter string                         ACT_TYPE         = "relu",
    parameter logic [127:0]                  BIAS_FILE        = '0,
    parameter logic [127:0]                  WEIGHT_FILE      = '0,
    // Memory image contents: weight j of this neuron sits at W_VAL[j*DATA_WIDTH +: DATA_WIDTH].
    parameter logic [WEIGHT_NUM*DATA_WIDTH-1:0] W_VAL         = '0,
    parameter logic [DATA_WIDTH-1:0]         B_VAL            = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);
    localparam int  FRAC = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam int  PW   = 2 * DATA_WIDTH;
    localparam int  CW   = $clog2(WEIGHT_NUM + 1);
    localparam bit  RELU = (ACT_TYPE == "relu");
    localparam logic signed [PW-1:0] SMAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    if (SIGMOID_SIZE < 1 || LAYER_NO < 0) begin : g_bad_cfg
        $error("nn_neuron: SIGMOID_SIZE must be positive and LAYER_NO non-negative");
    end
    if (BIAS_FILE == '0 || WEIGHT_FILE == '0) begin : g_bad_file
        $error("nn_neuron: memory image names must not be empty");
    end

    logic signed [PW-1:0]         acc_q, acc_d, prod, sum, scaled, bias_ext;
    logic        [CW-1:0]         cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] w_cur;
    logic        [DATA_WIDTH-1:0] res_q, res_d, sat;
    logic                         vld_q, vld_d;

    assign w_cur    = W_VAL[cnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign bias_ext = {{DATA_WIDTH{B_VAL[DATA_WIDTH-1]}}, B_VAL};

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        vld_d  = 1'b0;
        prod   = $signed(data_i) * w_cur;
        sum    = acc_q + prod;
        // Products carry 2*FRAC fraction bits; drop FRAC of them once, after the full sum.
        scaled = (sum >>> FRAC) + bias_ext;
        if (scaled > SMAX)      sat = SMAX[DATA_WIDTH-1:0];
        else if (scaled < SMIN) sat = SMIN[DATA_WIDTH-1:0];
        else                    sat = scaled[DATA_WIDTH-1:0];
        if (RELU && sat[DATA_WIDTH-1]) sat = '0;
        if (valid_i) begin
            if (cnt_q == CW'(WEIGHT_NUM - 1)) begin
                acc_d = '0;
                cnt_d = '0;
                res_d = sat;
                vld_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign data_o  = res_q;
    assign valid_o = vld_q;
endmodule

module nn_layer_stream #(
    parameter int    NEURON_NUM       = 10,
    parameter int    WEIGHT_NUM       = 30,
    parameter int    DATA_WIDTH       = 16,
    parameter int    LAYER_NO         = 4,
    parameter int    SIGMOID_SIZE     = 10,
    parameter int    WEIGHT_INT_WIDTH = 4,
    parameter string ACT_TYPE         = "relu",
    parameter string OUT_MODE         = "serial",
    // Weight/bias memory images, neuron n in the n-th slice; defaults are unit weights and zero bias.
    parameter logic [NEURON_NUM*WEIGHT_NUM*DATA_WIDTH-1:0] W_INIT =
        {(NEURON_NUM*WEIGHT_NUM){DATA_WIDTH'(1) << (DATA_WIDTH - WEIGHT_INT_WIDTH)}},
    parameter logic [NEURON_NUM*DATA_WIDTH-1:0] B_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_unexp
);
    localparam int CW     = $clog2(WEIGHT_NUM + 1);
    localparam int IW     = $clog2(NEURON_NUM + 1);
    localparam int SW     = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
    localparam bit ARGMAX = (OUT_MODE == "argmax");

    if (OUT_MODE != "serial" && OUT_MODE != "argmax") begin : g_bad_mode
        $error("nn_layer_stream: OUT_MODE must be \"serial\" or \"argmax\"");
    end
    if (NEURON_NUM < 1 || NEURON_NUM > 64 || WEIGHT_NUM < 1) begin : g_bad_size
        $error("nn_layer_stream: NEURON_NUM must be 1..64 and WEIGHT_NUM positive");
    end

    // Appends the decimal form of v (no padding) to a right-aligned character vector.
    function automatic logic [127:0] put_num(input logic [127:0] s_in, input int v);
        logic [127:0] s;
        s = s_in;
        for (int d = 10000; d >= 1; d = d / 10) begin
            if (v >= d || d == 1) s = {s[119:0], 8'(8'h30 + (v / d) % 10)};
        end
        return s;
    endfunction

    // Builds "<kind>_<layer>_<n>.mif".
    function automatic logic [127:0] mif_name(input logic [7:0] kind, input int layer, input int n);
        logic [127:0] s;
        s = 128'(kind);
        s = {s[119:0], 8'h5f};
        s = put_num(s, layer);
        s = {s[119:0], 8'h5f};
        s = put_num(s, n);
        s = {s[95:0], 32'h2e6d6966};
        return s;
    endfunction

    typedef enum logic [2:0] {S_ACCEPT, S_WAIT, S_SEND, S_ARG, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           in_cnt_q, in_cnt_d;
    logic [IW-1:0]           idx_q, idx_d, arg_q, arg_d;
    logic [SW-1:0]           sel;
    logic [NEURON_NUM-1:0]   flag_q, flag_d, n_vld;
    logic [DATA_WIDTH-1:0]   res_q [NEURON_NUM];
    logic [DATA_WIDTH-1:0]   res_d [NEURON_NUM];
    logic [DATA_WIDTH-1:0]   n_dat [NEURON_NUM];
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic                    err_q, err_d;
    logic                    live_q;
    logic                    beat;

    for (genvar g = 0; g < NEURON_NUM; g++) begin : g_neuron
        nn_neuron #(
            .DATA_WIDTH       (DATA_WIDTH),
            .WEIGHT_NUM       (WEIGHT_NUM),
            .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
            .SIGMOID_SIZE     (SIGMOID_SIZE),
            .LAYER_NO         (LAYER_NO),
            .ACT_TYPE         (ACT_TYPE),
            .BIAS_FILE        (mif_name("b", LAYER_NO, g)),
            .WEIGHT_FILE      (mif_name("w", LAYER_NO, g)),
            .W_VAL            (W_INIT[g*WEIGHT_NUM*DATA_WIDTH +: WEIGHT_NUM*DATA_WIDTH]),
            .B_VAL            (B_INIT[g*DATA_WIDTH +: DATA_WIDTH])
        ) u_neuron (
            .clk     (clk),
            .rst_n   (rst_n),
            .data_i  (in_data),
            .valid_i (beat),
            .data_o  (n_dat[g]),
            .valid_o (n_vld[g])
        );
    end

    // live_q keeps in_ready low through the reset cycle even though the state is already ACCEPT.
    assign in_ready  = live_q && (state_q == S_ACCEPT);
    assign beat      = in_valid && in_ready;
    assign busy      = (state_q != S_ACCEPT);
    assign err_unexp = err_q;
    assign sel       = idx_q[SW-1:0];

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        idx_d     = idx_q;
        arg_d     = arg_q;
        max_d     = max_q;
        flag_d    = flag_q;
        err_d     = err_q;
        res_d     = res_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;

        // Result capture; a result is only expected in WAIT and only once per neuron.
        if (state_q == S_WAIT) begin
            for (int i = 0; i < NEURON_NUM; i++) begin
                if (n_vld[i]) begin
                    res_d[i]  = n_dat[i];
                    flag_d[i] = 1'b1;
                    if (flag_q[i]) err_d = 1'b1;
                end
            end
            if (&flag_d) begin
                state_d = ARGMAX ? S_ARG : S_SEND;
                idx_d   = '0;
            end
        end else if (|n_vld) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_ACCEPT: begin
                if (beat) begin
                    if (in_cnt_q == CW'(WEIGHT_NUM - 1)) begin
                        in_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + CW'(1);
                    end
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = res_q[sel];
                out_last  = (idx_q == IW'(NEURON_NUM - 1));
                if (out_ready) begin
                    if (out_last) begin
                        idx_d   = '0;
                        flag_d  = '0;
                        state_d = S_ACCEPT;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_ARG: begin
                // Strict greater-than: on ties the earlier (lower) index is kept.
                if (idx_q == '0 || $signed(res_q[sel]) > $signed(max_q)) begin
                    max_d = res_q[sel];
                    arg_d = idx_q;
                end
                if (idx_q == IW'(NEURON_NUM - 1)) begin
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = DATA_WIDTH'(arg_q);
                out_last  = 1'b1;
                if (out_ready) begin
                    flag_d  = '0;
                    state_d = S_ACCEPT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ACCEPT;
            in_cnt_q <= '0;
            idx_q    <= '0;
            arg_q    <= '0;
            max_q    <= '0;
            flag_q   <= '0;
            err_q    <= 1'b0;
            live_q   <= 1'b0;
            for (int i = 0; i < NEURON_NUM; i++) res_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            idx_q    <= idx_d;
            arg_q    <= arg_d;
            max_q    <= max_d;
            flag_q   <= flag_d;
            err_q    <= err_d;
            live_q   <= 1'b1;
            res_q    <= res_d;
        end
    end
endmodule

// File: tb/tb_nn_layer_stream.sv
// Bench for nn_layer_stream: a 4-neuron, 3-input layer in serial mode and one in argmax mode.
// Expected results come from the layer's arithmetic with unit weights: relu(sum of inputs + bias).
module tb_nn_layer_stream;
    localparam int DW = 16;
    localparam int NN = 4;
    localparam int WN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [DW-1:0] s_in_data, s_out_data, a_in_data, a_out_data;
    logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_busy, s_err;
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy, a_err;

    nn_layer_stream #(
        .NEURON_NUM(NN), .WEIGHT_NUM(WN), .DATA_WIDTH(DW), .OUT_MODE("serial"),
        .B_INIT({16'h0C00, 16'h0800, 16'h0400, 16'h0000})
    ) u_ser (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_last(s_out_last),
        .busy(s_busy), .err_unexp(s_err)
    );

    nn_layer_stream #(
        .NEURON_NUM(NN), .WEIGHT_NUM(WN), .DATA_WIDTH(DW), .OUT_MODE("argmax"),
        .B_INIT({16'hF000, 16'h2000, 16'h2000, 16'h0800})
    ) u_arg (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
        .busy(a_busy), .err_unexp(a_err)
    );

    int checks = 0;
    int errors = 0;
    int sb[NN] = '{0, 1024, 2048, 3072};
    int ab[NN] = '{2048, 8192, 8192, -4096};
    int exp_q[$];
    int got_q[$];
    int last_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Unit weights (1.0) make each product equal to its input; relu clamps at 0.
    function automatic int model(input int x0, input int x1, input int x2, input int b);
        int s;
        s = x0 + x1 + x2 + b;
        if (s > 32767) s = 32767;
        if (s < 0) s = 0;
        return s;
    endfunction

    function automatic int rnd_x();
        return int'($urandom_range(0, 16384)) - 8192;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        s_in_valid = 1'b0; a_in_valid = 1'b0;
        s_out_ready = 1'b0; a_out_ready = 1'b0;
        #1;
        chk("rst_in_ready", s_in_ready, 0);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_data", s_out_data, 0);
        chk("rst_out_last", s_out_last, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_err", s_err, 0);
        chk("rst_a_out_valid", a_out_valid, 0);
        tick();
        rst_n = 1'b1;
        chk("rdy_release_cycle", s_in_ready, 0);
        tick();
        chk("rdy_after_release", s_in_ready, 1);
        chk("a_rdy_after_release", a_in_ready, 1);
    endtask

    task automatic feed(input bit arg, input int x0, input int x1, input int x2, input bit gaps);
        int xs[3];
        xs = '{x0, x1, x2};
        for (int k = 0; k < 3; k++) begin
            if (gaps && k > 0) begin
                s_in_valid = 1'b0; a_in_valid = 1'b0;
                tick();
            end
            if (arg) begin
                a_in_valid = 1'b1; a_in_data = 16'(xs[k]);
                chk("a_rdy_beat", a_in_ready, 1);
            end else begin
                s_in_valid = 1'b1; s_in_data = 16'(xs[k]);
                chk("rdy_beat", s_in_ready, 1);
            end
            tick();
        end
        if (arg) begin
            a_in_valid = 1'b0;
            chk("a_rdy_low_after_last", a_in_ready, 0);
            chk("a_busy_after_last", a_busy, 1);
        end else begin
            // With gaps, keep offering a 4th word that must not be consumed.
            s_in_valid = gaps;
            s_in_data  = 16'h7FFF;
            chk("rdy_low_after_last", s_in_ready, 0);
            chk("busy_after_last", s_busy, 1);
        end
    endtask

    task automatic set_exp(input int x0, input int x1, input int x2);
        exp_q.delete();
        for (int n = 0; n < NN; n++) exp_q.push_back(model(x0, x1, x2, sb[n]));
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1,...; 2: random ready.
    task automatic collect(input int mode);
        int cyc, n, first_vld, hs_first, hs_last;
        logic [DW-1:0] held;
        logic held_last;
        bit stalled, rdy;
        cyc = 0; n = 0; first_vld = -1; hs_first = 0; hs_last = 0;
        stalled = 1'b0; held = '0; held_last = 1'b0;
        got_q.delete(); last_q.delete();
        while (n < NN && cyc < 200) begin
            tick();
            cyc++;
            if (stalled) begin
                chk("stall_valid", s_out_valid, 1);
                chk("stall_data", s_out_data, held);
                chk("stall_last", s_out_last, held_last);
                stalled = 1'b0;
            end
            chk("rdy_low_until_done", s_in_ready, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            s_out_ready = rdy;
            if (s_out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (rdy) begin
                    got_q.push_back(int'(s_out_data));
                    last_q.push_back(int'(s_out_last));
                    if (n == 0) hs_first = cyc;
                    hs_last = cyc;
                    n++;
                    if (n == NN) s_in_valid = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = s_out_data;
                    held_last = s_out_last;
                end
            end
        end
        chk("handshake_count", n, NN);
        tick();
        chk("rdy_back_after_last", s_in_ready, 1);
        chk("valid_low_after_last", s_out_valid, 0);
        chk("busy_low_after_last", s_busy, 0);
        for (int i = 0; i < n; i++) begin
            chk("word", got_q[i], exp_q[i]);
            chk("last_flag", last_q[i], (i == NN - 1) ? 1 : 0);
        end
        if (mode == 0) begin
            chk("first_word_latency", first_vld, 1);
            chk("burst_length", hs_last - hs_first, NN - 1);
        end
        chk("err_clear", s_err, 0);
    endtask

    task automatic run_arg(input int x0, input int x1, input int x2);
        int r[NN];
        int best, cyc, first_vld;
        bit seen, done;
        for (int n = 0; n < NN; n++) r[n] = model(x0, x1, x2, ab[n]);
        best = 0;
        for (int n = 1; n < NN; n++) if (r[n] > r[best]) best = n;
        feed(1'b1, x0, x1, x2, 1'b0);
        cyc = 0; first_vld = -1; seen = 1'b0; done = 1'b0;
        a_out_ready = 1'b0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            if (a_out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                chk("arg_index", a_out_data, best);
                chk("arg_last", a_out_last, 1);
                if (seen) begin
                    a_out_ready = 1'b1;
                    done = 1'b1;
                end
                seen = 1'b1;
            end
        end
        chk("arg_done", done, 1);
        chk("arg_latency", first_vld, NN + 1);
        tick();
        a_out_ready = 1'b0;
        chk("arg_rdy_back", a_in_ready, 1);
        chk("arg_valid_low", a_out_valid, 0);
        chk("arg_err_clear", a_err, 0);
    endtask

    initial begin
        int x0, x1, x2;
        rst_n = 1'b0;
        s_in_data = '0; a_in_data = '0;
        s_in_valid = 1'b0; a_in_valid = 1'b0;
        s_out_ready = 1'b0; a_out_ready = 1'b0;
        tick();
        do_reset();

        // Three beats of 0.5 -> 1.50, 1.75, 2.00, 2.25.
        set_exp(16'h0800, 16'h0800, 16'h0800);
        chk("fixed_expect_w0", exp_q[0], 32'h1800);
        chk("fixed_expect_w3", exp_q[3], 32'h2400);
        feed(1'b0, 16'h0800, 16'h0800, 16'h0800, 1'b0);
        collect(0);

        // Backpressure 1,0,0,1,...
        feed(1'b0, 16'h0800, 16'h0800, 16'h0800, 1'b0);
        collect(1);

        // Input gaps plus a 4th word offered while waiting.
        feed(1'b0, 16'h0800, 16'h0800, 16'h0800, 1'b1);
        collect(0);

        // Argmax with zero inputs: tie between neurons 1 and 2 resolves to 1.
        run_arg(0, 0, 0);

        // Reset after two beats, then a clean sample.
        s_in_valid = 1'b1; s_in_data = 16'h1000; tick();
        s_in_data = 16'h1000; tick();
        do_reset();
        x0 = rnd_x(); x1 = rnd_x(); x2 = rnd_x();
        set_exp(x0, x1, x2);
        feed(1'b0, x0, x1, x2, 1'b0);
        collect(0);

        // Reset while words are being sent.
        feed(1'b0, 16'h0400, 16'h0400, 16'h0400, 1'b0);
        s_out_ready = 1'b0;
        tick(); tick();
        chk("send_active", s_out_valid, 1);
        do_reset();

        // Back-to-back samples with out_ready held high.
        for (int s = 0; s < 2; s++) begin
            x0 = rnd_x(); x1 = rnd_x(); x2 = rnd_x();
            set_exp(x0, x1, x2);
            feed(1'b0, x0, x1, x2, 1'b0);
            collect(0);
        end

        // Random samples, random gaps, random backpressure.
        for (int s = 0; s < 6; s++) begin
            x0 = rnd_x(); x1 = rnd_x(); x2 = rnd_x();
            set_exp(x0, x1, x2);
            feed(1'b0, x0, x1, x2, 1'($urandom_range(0, 1)));
            collect(2);
        end

        // Random argmax samples.
        for (int s = 0; s < 4; s++) begin
            run_arg(rnd_x(), rnd_x(), rnd_x());
        end

        chk("final_err_serial", s_err, 0);
        chk("final_err_argmax", a_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
